// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared frame geometry and capture state type
package cam_pkg;

  localparam int HREZ = 160;
  localparam int VREZ = 120;
  localparam int TREZ = HREZ * VREZ;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_SOF = 2'd2,
    CAPTURE  = 2'd3
  } cap_state_t;

  // Counter needs one extra code beyond the last address to represent "full".
  function automatic int cnt_width(input int trez);
    return $clog2(trez + 1);
  endfunction

endpackage

// File: rtl/capture_addr_counter.sv
// rtl/capture_addr_counter.sv - saturating pixel counter that doubles as the write address
module capture_addr_counter #(
  parameter int TREZ  = cam_pkg::TREZ,
  parameter int CNT_W = cam_pkg::cnt_width(cam_pkg::TREZ)
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_pix_cnt,
  output logic             o_full
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full    = (r_cnt == CNT_W'(TREZ));
  assign o_pix_cnt = r_cnt;
  assign o_full    = w_full;

  // Clear wins so a re-arm in the same cycle as a stray increment starts at 0.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - single-shot/continuous frame capture sequencer for the frame buffer
module frame_capture_ctrl #(
  parameter int HREZ   = cam_pkg::HREZ,
  parameter int VREZ   = cam_pkg::VREZ,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk25,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              short_frame,
  output logic [15:0]       frame_count
);

  import cam_pkg::*;

  localparam int TREZ  = HREZ * VREZ;
  localparam int CNT_W = ADDR_W + 1;

  cap_state_t       r_state;
  logic             r_vsync_d;
  logic             r_cont;
  logic             w_rise;
  logic             w_fall;
  logic             w_clr;
  logic             w_inc;
  logic             w_full;
  logic [CNT_W-1:0] w_pix_cnt;

  assign w_rise = vsync & ~r_vsync_d;
  assign w_fall = ~vsync & r_vsync_d;

  // Counter control mirrors the FSM transitions below; abort freezes it.
  assign w_clr = !abort && (((r_state == IDLE) && start) ||
                            ((r_state == WAIT_SOF) && w_rise) ||
                            ((r_state == CAPTURE) && w_fall && r_cont));
  assign w_inc = !abort && (r_state == CAPTURE) && !w_fall && pix_valid && !w_full;

  capture_addr_counter #(
    .TREZ  (TREZ),
    .CNT_W (CNT_W)
  ) u_addr_cnt (
    .clk25     (clk25),
    .reset_n   (reset_n),
    .i_clear   (w_clr),
    .i_inc     (w_inc),
    .o_pix_cnt (w_pix_cnt),
    .o_full    (w_full)
  );

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_vsync_d   <= 1'b0;
      r_cont      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      frame_count <= '0;
    end else begin
      r_vsync_d <= vsync;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state     <= ARM;
              busy        <= 1'b1;
              r_cont      <= continuous;
              overflow    <= 1'b0;
              short_frame <= 1'b0;
            end
          end
          // Wait for blanking so a frame already underway is never taken partially.
          ARM: begin
            if (!vsync) begin
              r_state <= WAIT_SOF;
            end
          end
          WAIT_SOF: begin
            if (w_rise) begin
              r_state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (w_fall) begin
              done        <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (!w_full) begin
                short_frame <= 1'b1;
              end
              if (r_cont) begin
                r_state <= WAIT_SOF;
              end else begin
                r_state <= IDLE;
                busy    <= 1'b0;
              end
            end else if (pix_valid) begin
              if (w_full) begin
                overflow <= 1'b1;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(w_pix_cnt);
                wr_data <= pix_data;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - randomized self-checking bench with behavioural capture model
module tb_frame_capture_ctrl;

  localparam int HREZ   = 160;
  localparam int VREZ   = 120;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int TREZ   = HREZ * VREZ;

  logic              clk25      = 1'b0;
  logic              reset_n    = 1'b0;
  logic              start      = 1'b0;
  logic              continuous = 1'b0;
  logic              abort      = 1'b0;
  logic              vsync      = 1'b0;
  logic              pix_valid  = 1'b0;
  logic [DATA_W-1:0] pix_data   = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              short_frame;
  logic [15:0]       frame_count;

  frame_capture_ctrl #(
    .HREZ(HREZ), .VREZ(VREZ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk25(clk25), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow), .short_frame(short_frame), .frame_count(frame_count)
  );

  always #5 clk25 = ~clk25;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what the capture rules say each registered output must be.
  localparam int M_IDLE = 0, M_WAIT_LOW = 1, M_WAIT_RISE = 2, M_CAPTURE = 3;
  int m_phase   = M_IDLE;
  int m_cnt     = 0;
  bit m_cont    = 1'b0;
  bit m_prev_vs = 1'b0;
  bit e_wr_en = 0, e_done = 0, e_ovf = 0, e_short = 0, e_busy = 0;
  int e_addr = 0, e_data = 0, e_fc = 0;

  initial forever begin
    @(posedge clk25 or negedge reset_n);
    if (!reset_n) begin
      m_phase = M_IDLE; m_cnt = 0; m_cont = 0; m_prev_vs = 0;
      e_wr_en = 0; e_done = 0; e_ovf = 0; e_short = 0; e_busy = 0;
      e_addr = 0; e_data = 0; e_fc = 0;
    end else begin
      bit rise, fall;
      rise = !m_prev_vs && vsync;
      fall = m_prev_vs && !vsync;
      e_wr_en = 0;
      e_done  = 0;
      if (abort) begin
        m_phase = M_IDLE;
      end else if (m_phase == M_IDLE) begin
        if (start) begin
          m_phase = M_WAIT_LOW; m_cont = continuous; e_ovf = 0; e_short = 0; m_cnt = 0;
        end
      end else if (m_phase == M_WAIT_LOW) begin
        if (!vsync) m_phase = M_WAIT_RISE;
      end else if (m_phase == M_WAIT_RISE) begin
        if (rise) begin m_phase = M_CAPTURE; m_cnt = 0; end
      end else begin
        if (fall) begin
          e_done = 1;
          e_fc = (e_fc + 1) % 65536;
          if (m_cnt < TREZ) e_short = 1;
          if (m_cont) begin m_phase = M_WAIT_RISE; m_cnt = 0; end
          else m_phase = M_IDLE;
        end else if (pix_valid) begin
          if (m_cnt < TREZ) begin
            e_wr_en = 1; e_addr = m_cnt; e_data = int'(pix_data); m_cnt++;
          end else begin
            e_ovf = 1;
          end
        end
      end
      m_prev_vs = vsync;
      e_busy = (m_phase != M_IDLE);
    end
  end

  // Scoreboard of observed writes and pulses, cleared per scenario.
  int n_wr = 0, first_addr = -1, last_addr = -1, n_done = 0, n_zero = 0;
  bit busy_dropped = 0;

  initial forever begin
    @(negedge clk25);
    #1;
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), e_addr);
      chk("wr_data", 32'(wr_data), e_data);
    end
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("short_frame", 32'(short_frame), 32'(e_short));
    chk("frame_count", 32'(frame_count), e_fc);
    if (wr_en) begin
      if (n_wr == 0) first_addr = int'(wr_addr);
      last_addr = int'(wr_addr);
      if (wr_addr == 0) n_zero++;
      n_wr++;
    end
    if (done) n_done++;
    if (!busy) busy_dropped = 1;
  end

  task automatic tick();
    @(negedge clk25);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_sb();
    n_wr = 0; first_addr = -1; last_addr = -1; n_done = 0; n_zero = 0; busy_dropped = 0;
  endtask

  task automatic do_start(input bit c);
    start = 1; continuous = c;
    tick();
    start = 0; continuous = 1'($urandom_range(1));
  endtask

  task automatic frame(input int npix, input bit gaps);
    int sent = 0;
    vsync = 0; pix_valid = 0;
    repeat (3) tick();
    vsync = 1; pix_valid = 1'($urandom_range(1)); pix_data = DATA_W'($urandom);
    tick();
    while (sent < npix) begin
      if (gaps && $urandom_range(3) == 0) pix_valid = 0;
      else begin pix_valid = 1; pix_data = DATA_W'($urandom); sent++; end
      tick();
    end
    vsync = 0; pix_valid = 1'($urandom_range(1)); pix_data = DATA_W'($urandom);
    tick();
    pix_valid = 0;
    repeat (4) tick();
  endtask

  initial begin
    int sum;
    repeat (3) tick();
    settle();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    reset_n = 1;
    repeat (2) tick();

    // Single-shot full frame at full rate
    clr_sb(); do_start(0); frame(TREZ, 0); settle();
    chk("ss_writes", n_wr, TREZ);
    chk("ss_first_addr", first_addr, 0);
    chk("ss_last_addr", last_addr, TREZ - 1);
    chk("ss_done", n_done, 1);
    chk("ss_frame_count", 32'(frame_count), 1);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_flags", {30'd0, overflow, short_frame}, 0);

    // Start while a frame is already running
    clr_sb(); vsync = 1; pix_valid = 1;
    repeat (10) begin pix_data = DATA_W'($urandom); tick(); end
    start = 1; tick(); start = 0;
    repeat (50) begin pix_valid = 1'($urandom_range(1)); pix_data = DATA_W'($urandom); tick(); end
    settle();
    chk("mid_no_write", n_wr, 0);
    frame(300, 1); settle();
    chk("mid_writes", n_wr, 300);
    chk("mid_first_addr", first_addr, 0);
    chk("mid_short", 32'(short_frame), 1);
    chk("mid_frame_count", 32'(frame_count), 2);

    // Overflow
    clr_sb(); do_start(0); frame(TREZ + 5, 0); settle();
    chk("ovf_writes", n_wr, TREZ);
    chk("ovf_last_addr", last_addr, TREZ - 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_short", 32'(short_frame), 0);

    // Short frame
    clr_sb(); do_start(0); frame(100, 1); settle();
    chk("short_flag", 32'(short_frame), 1);
    chk("short_ovf_cleared", 32'(overflow), 0);
    chk("short_done", n_done, 1);
    chk("short_writes", n_wr, 100);
    chk("short_frame_count", 32'(frame_count), 4);

    // Continuous, three frames
    do_start(1); clr_sb(); sum = 0;
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(1500, 500);
      sum += n;
      frame(n, 1);
    end
    settle();
    chk("cont_frame_count", 32'(frame_count), 7);
    chk("cont_done", n_done, 3);
    chk("cont_addr0_writes", n_zero, 3);
    chk("cont_writes", n_wr, sum);
    chk("cont_busy_held", 32'(busy_dropped), 0);
    abort = 1; tick(); abort = 0; settle();
    chk("cont_abort_idle", 32'(busy), 0);

    // Abort at pixel 500
    clr_sb(); do_start(0);
    vsync = 0; repeat (3) tick();
    vsync = 1; tick();
    repeat (500) begin pix_valid = 1; pix_data = DATA_W'($urandom); tick(); end
    abort = 1; tick(); abort = 0; pix_valid = 0; settle();
    chk("abort_idle", 32'(busy), 0);
    vsync = 0; repeat (4) tick(); settle();
    chk("abort_writes", n_wr, 500);
    chk("abort_no_done", n_done, 0);
    chk("abort_frame_count", 32'(frame_count), 7);

    // Start and abort together
    start = 1; abort = 1; tick(); start = 0; abort = 0; settle();
    chk("start_abort_idle", 32'(busy), 0);
    tick(); settle();
    chk("start_abort_idle2", 32'(busy), 0);

    // Random traffic
    repeat (4000) begin
      start      = ($urandom_range(40) == 0);
      continuous = 1'($urandom_range(1));
      abort      = ($urandom_range(200) == 0);
      if ($urandom_range(250) == 0) vsync = ~vsync;
      pix_valid  = 1'($urandom_range(1));
      pix_data   = DATA_W'($urandom);
      tick();
    end
    start = 0; abort = 1; pix_valid = 0; tick(); abort = 0;

    // Reset in the middle of a capture
    do_start(0);
    vsync = 0; repeat (3) tick();
    vsync = 1; tick();
    repeat (200) begin pix_valid = 1; pix_data = DATA_W'($urandom); tick(); end
    settle();
    chk("pre_reset_wr_en", 32'(wr_en), 1);
    chk("pre_reset_fc_nonzero", 32'(frame_count != 0), 1);
    reset_n = 0;
    #1;
    chk("rst_mid_wr_en", 32'(wr_en), 0);
    chk("rst_mid_wr_addr", 32'(wr_addr), 0);
    chk("rst_mid_wr_data", 32'(wr_data), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_flags", {30'd0, overflow, short_frame}, 0);
    chk("rst_mid_frame_count", 32'(frame_count), 0);
    tick(); pix_valid = 0; vsync = 0;
    repeat (2) tick();
    reset_n = 1;
    repeat (3) tick();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences one camera frame into the frame buffer: arms on a software/host start request, aligns to a clean frame boundary using `vsync`, generates buffer write strobes and addresses for each pixel, and reports completion, overflow and short-frame status. Sits between the camera pixel assembler and the frame-buffer write port, and replaces free-running address generation with a controlled single-shot or continuous capture.

## Interface
- `HREZ`, 160, pixels per line
- `VREZ`, 120, lines per frame
- `ADDR_W`, 17, write address width; must satisfy 2^ADDR_W ≥ HREZ*VREZ
- `DATA_W`, 12, pixel width
- `clk25`  in  1  pixel clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle capture request; ignored while `busy`
- `continuous`  in  1  sampled at `start`; 1 = re-arm after each frame
- `abort`  in  1  stop capture at once; wins over `start`
- `vsync`  in  1  high = active frame, low = vertical blanking; already synchronous to `clk25`
- `pix_valid`  in  1  one assembled pixel present on `pix_data`
- `pix_data`  in  DATA_W  pixel value
- `wr_en`  out  1  frame-buffer write strobe
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  DATA_W  write data
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of each captured frame
- `overflow`  out  1  sticky: pixel arrived with buffer full
- `short_frame`  out  1  sticky: frame ended with fewer than HREZ*VREZ pixels
- `frame_count`  out  16  completed frames, wraps at 65535→0

## Operation
- TREZ = HREZ*VREZ (19200 by default). Pixel counter `pix_cnt` ranges 0..TREZ.
- States: IDLE, ARM, WAIT_SOF, CAPTURE.
- IDLE: on `start` and not `abort` → ARM; latch `continuous`; clear `overflow` and `short_frame`; `pix_cnt` ← 0.
- ARM: wait for `vsync` = 0, so a frame already in progress is never captured partially → WAIT_SOF.
- WAIT_SOF: on `vsync` rising edge (`vsync_d`=0, `vsync`=1) → CAPTURE with `pix_cnt` = 0.
- CAPTURE with `pix_valid`:
  - `pix_cnt` < TREZ: write `pix_data` at address `pix_cnt`, then increment.
  - `pix_cnt` = TREZ: no write; set `overflow`.
- CAPTURE on `vsync` falling edge:
  - pulse `done`; increment `frame_count`.
  - Set `short_frame` if `pix_cnt` < TREZ.
  - Latched continuous = 1 → WAIT_SOF with `pix_cnt` ← 0; else → IDLE.
  - A `pix_valid` in the same cycle as the falling edge is discarded.
- `abort` in any state: → IDLE next cycle. No `done` pulse and no further writes. Sticky flags and `frame_count` are kept.
- `pix_valid` outside CAPTURE is ignored.

## Timing
- Reset values: state IDLE; `vsync_d`, `pix_cnt`, `wr_en`, `wr_addr`, `wr_data`, `done`, `overflow`, `short_frame` and `frame_count` all 0; `busy` 0.
- All outputs registered. `wr_en`/`wr_addr`/`wr_data` appear 1 cycle after the `pix_valid` sample and are held for 1 cycle.
- `done` is asserted the cycle after the `vsync` fall is detected.
- `busy` rises the cycle after accepted `start` and falls the cycle after the IDLE transition.
- `vsync` rising edge to first possible write: the next `pix_valid` sampled in CAPTURE, plus 1 cycle.
- Back-to-back `pix_valid` on every cycle is supported at full rate.

## Structure
- Shared package `cam_pkg`:
  - `HREZ`, `VREZ`, `TREZ` defaults
  - `cap_state_t` enum {IDLE, ARM, WAIT_SOF, CAPTURE}
- One natural sub-module, `capture_addr_counter`:
  - Inputs: clear, increment enable.
  - Outputs: `pix_cnt`, `full` (`pix_cnt` = TREZ).
  - FSM and status registers stay in the top module.

## Test plan
- Single-shot: `start` with `vsync` low, then a frame of 19200 `pix_valid` and a `vsync` fall:
  - 19200 writes at addresses 0..19199, each carrying the data sent.
  - 1 `done` pulse; `frame_count` = 1; returns to IDLE; both flags 0.
- Start mid-frame: `start` while `vsync` high:
  - No writes until `vsync` goes low and then high again.
  - First write address 0.
- Overflow and short frame:
  - 19205 pixels in one frame → 19200 writes, `overflow` = 1.
  - Next start, 100 pixels then `vsync` fall → `short_frame` = 1, `done` pulses.
- Continuous mode: 3 frames with `continuous` = 1:
  - `frame_count` = 3; each frame restarts at address 0.
  - `busy` stays 1 throughout.
- Abort and reset:
  - `abort` at pixel 500 → no `done`; `frame_count` unchanged; IDLE next cycle.
  - `start` and `abort` in the same cycle → stays IDLE.
  - `reset_n` low mid-CAPTURE → all outputs 0 immediately.
